// File: rtl/ysyx_23060072_redirect_ctrl.sv
// Control-flow redirect controller: boot redirect, taken-jump kill/redirect,
// load-use bubbles and the FENCE_I I-cache flush (enabled by YSYX_23060072_FENCE_I_EN).
module ysyx_23060072_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_pc_i,
    input  logic        ex_fence_i_i,
    input  logic        load_use_hazard_i,
    input  logic        ifu_ready_i,
    input  logic        icache_flush_done_i,
    output logic        ifu_redirect_valid_o,
    output logic [31:0] ifu_redirect_pc_o,
    output logic        icache_flush_req_o,
    output logic        stall_pc_o,
    output logic        stall_if_id_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic [31:0] redirect_cnt_o,
    output logic [1:0]  fsm_state
);
    // Handshake: ifu_redirect_valid_o rises with a stable ifu_redirect_pc_o and
    // holds both until the cycle ifu_ready_i is sampled high; that cycle completes it.
    localparam logic [1:0] BOOT       = 2'd0;
    localparam logic [1:0] IDLE       = 2'd1;
    localparam logic [1:0] FENCE_WAIT = 2'd2;
    localparam logic [1:0] REDIRECT   = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [31:0] redirect_pc;
    logic [31:0] redirect_cnt;
    logic        take;
    logic        fence_take;

    assign take = ex_valid_i & jump_flag_i;

`ifdef YSYX_23060072_FENCE_I_EN
    assign fence_take = ex_fence_i_i;
`else
    assign fence_take = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            BOOT:     if (ifu_ready_i) state_n = IDLE;
            IDLE:     if (take) state_n = fence_take ? FENCE_WAIT : REDIRECT;
`ifdef YSYX_23060072_FENCE_I_EN
            FENCE_WAIT: if (icache_flush_done_i) state_n = REDIRECT;
`endif
            REDIRECT: if (ifu_ready_i) state_n = IDLE;
            default:  state_n = BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= BOOT;
            redirect_pc  <= RESET_PC;
            redirect_cnt <= 32'd0;
        end else begin
            state <= state_n;
            if (state == IDLE && take)
                redirect_pc <= jump_pc_i;
            if (state == REDIRECT && ifu_ready_i)
                redirect_cnt <= redirect_cnt + 32'd1;
        end
    end

    // Every non-IDLE state freezes the PC and keeps both pipeline registers empty.
    always_comb begin
        ifu_redirect_valid_o = 1'b0;
        stall_pc_o           = 1'b0;
        stall_if_id_o        = 1'b0;
        flush_if_id_o        = 1'b0;
        flush_id_ex_o        = 1'b0;
        if (state == IDLE) begin
            if (take) begin
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
            end else if (load_use_hazard_i) begin
                stall_pc_o    = 1'b1;
                stall_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
            end
        end else begin
            ifu_redirect_valid_o = (state == BOOT) || (state == REDIRECT);
            stall_pc_o           = 1'b1;
            flush_if_id_o        = 1'b1;
            flush_id_ex_o        = 1'b1;
        end
    end

`ifdef YSYX_23060072_FENCE_I_EN
    assign icache_flush_req_o = (state == FENCE_WAIT);
`else
    assign icache_flush_req_o = 1'b0;
`endif

    assign ifu_redirect_pc_o = redirect_pc;
    assign redirect_cnt_o    = redirect_cnt;
    assign fsm_state         = state;
endmodule

// File: tb/tb_ysyx_23060072_redirect_ctrl.sv
// Bench for ysyx_23060072_redirect_ctrl: directed scenarios then random traffic,
// all checked against a pending-work model of the controller.
module tb_ysyx_23060072_redirect_ctrl;
    localparam logic [31:0] RESET_PC = 32'h3000_0000;
`ifdef YSYX_23060072_FENCE_I_EN
    localparam bit FENCE_EN = 1'b1;
`else
    localparam bit FENCE_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid, jump_flag, ex_fence, load_use, ifu_ready, flush_done;
    logic [31:0] jump_pc;
    logic        redir_valid, flush_req, stall_pc, stall_if_id, flush_if_id, flush_id_ex;
    logic [31:0] redir_pc, redir_cnt;
    logic [1:0]  fsm_state;

    int checks = 0;
    int fails  = 0;

    // Model: what work is outstanding, not how the controller encodes it.
    bit          booting, fencing, redirecting;
    logic [31:0] m_pc, m_cnt;

    always #5 clock = ~clock;

    ysyx_23060072_redirect_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset),
        .ex_valid_i(ex_valid), .jump_flag_i(jump_flag), .jump_pc_i(jump_pc),
        .ex_fence_i_i(ex_fence), .load_use_hazard_i(load_use),
        .ifu_ready_i(ifu_ready), .icache_flush_done_i(flush_done),
        .ifu_redirect_valid_o(redir_valid), .ifu_redirect_pc_o(redir_pc),
        .icache_flush_req_o(flush_req), .stall_pc_o(stall_pc),
        .stall_if_id_o(stall_if_id), .flush_if_id_o(flush_if_id),
        .flush_id_ex_o(flush_id_ex), .redirect_cnt_o(redir_cnt),
        .fsm_state(fsm_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit ev, input bit jf, input logic [31:0] pc, input bit fn,
                         input bit hz, input bit rdy, input bit dn, input bit rst);
        ex_valid = ev; jump_flag = jf; jump_pc = pc; ex_fence = fn;
        load_use = hz; ifu_ready = rdy; flush_done = dn; reset = rst;
    endtask

    // Check one cycle's outputs, then advance the model across the edge.
    task automatic step();
        bit busy, idle, take, hz;
        busy = booting | fencing | redirecting;
        idle = !busy;
        take = idle & ex_valid & jump_flag;
        hz   = idle & load_use & !take;
        #1;
        chk("redirect_valid", {31'd0, redir_valid}, {31'd0, booting | redirecting});
        chk("redirect_pc", redir_pc, m_pc);
        chk("flush_req", {31'd0, flush_req}, {31'd0, fencing});
        chk("stall_pc", {31'd0, stall_pc}, {31'd0, busy | hz});
        chk("stall_if_id", {31'd0, stall_if_id}, {31'd0, hz});
        chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, busy | take});
        chk("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, busy | take | hz});
        chk("redirect_cnt", redir_cnt, m_cnt);
        @(posedge clock);
        if (reset) begin
            booting = 1; fencing = 0; redirecting = 0; m_pc = RESET_PC; m_cnt = 0;
        end else if (booting) begin
            if (ifu_ready) booting = 0;
        end else if (redirecting) begin
            if (ifu_ready) begin redirecting = 0; m_cnt = m_cnt + 1; end
        end else if (fencing) begin
            if (flush_done) begin fencing = 0; redirecting = 1; end
        end else if (take) begin
            m_pc = jump_pc;
            if (FENCE_EN && ex_fence) fencing = 1; else redirecting = 1;
        end
        @(negedge clock);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clock);
        @(negedge clock);
        booting = 1; fencing = 0; redirecting = 0; m_pc = RESET_PC; m_cnt = 0;
        step();

        // Boot redirect: ready only on the third cycle after release.
        drive(0, 0, 0, 0, 0, 0, 0, 0); step(); step();
        drive(0, 0, 0, 0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();

        // Taken branch, IFU stalls three cycles before accepting.
        drive(1, 1, 32'h8000_0100, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step(); step(); step();
        drive(0, 0, 0, 0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();

        // Jump and load-use together; jump wins.
        drive(1, 1, 32'h8000_0200, 0, 1, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();

        // Load-use alone for two cycles, with a stray ready in IDLE.
        drive(0, 0, 0, 0, 1, 1, 0, 0); step(); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();

        // FENCE_I at 0x8000_0000 resolving to pc+4, done five cycles later.
        drive(1, 1, 32'h8000_0004, 1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step(); step(); step(); step();
        drive(0, 0, 0, 0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step(); step();

        // Reset in the middle of a pending redirect.
        drive(1, 1, 32'h8000_0300, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
                  {$urandom_range(0, 32'h3fff_ffff), 2'b00}, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
